// File: rtl/instr_fetch_mem_pkg.sv
// Shared types, constants and helpers for the loadable instruction store and its fetch engine.
// Latency: none (declarations and pure functions only).
// Backpressure: not applicable.
package instr_pkg;

    localparam int unsigned IW_DEF  = 20;
    localparam int unsigned AW_DEF  = 9;
    localparam int unsigned OPW_DEF = 5;

    // Opcode that terminates execution once the core consumes it.
    localparam logic [OPW_DEF-1:0] DONE_OP = 5'b01110;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_e;

    // Word returned for unloaded entries: done opcode in the MSBs, zero operand field.
    // Computed in a 32-bit container so it works for any IW up to 32.
    function automatic logic [31:0] done_word(input int unsigned iw,
                                              input int unsigned opw,
                                              input logic [31:0]  op);
        return op << (iw - opw);
    endfunction

    // Opcode field inst[iw-1 -: opw], right-aligned in a 32-bit container.
    function automatic logic [31:0] get_op(input logic [31:0]  inst,
                                           input int unsigned iw,
                                           input int unsigned opw);
        return (inst >> (iw - opw)) & ((32'd1 << opw) - 32'd1);
    endfunction

endpackage

// File: rtl/instr_fetch_mem_if.sv
// Load-port and fetch-port bundle between the loader/core side and the instruction store.
// Latency: wires only.
// Backpressure: stall/redirect flow from core to store; ld_ready gates the load side.
interface instr_fetch_mem_if #(
    parameter int unsigned IW = instr_pkg::IW_DEF,
    parameter int unsigned AW = instr_pkg::AW_DEF
);
    logic          ld_en;
    logic [AW-1:0] ld_addr;
    logic [IW-1:0] ld_data;
    logic          ld_ready;
    logic          clear;
    logic          start;
    logic [AW-1:0] start_pc;
    logic          stall;
    logic          redirect;
    logic [AW-1:0] redirect_pc;
    logic [IW-1:0] inst;
    logic [AW-1:0] inst_pc;
    logic          inst_valid;
    logic          halted;

    // Loader / core side.
    modport master (
        output ld_en, ld_addr, ld_data, clear, start, start_pc,
               stall, redirect, redirect_pc,
        input  ld_ready, inst, inst_pc, inst_valid, halted
    );

    // Instruction store side.
    modport slave (
        input  ld_en, ld_addr, ld_data, clear, start, start_pc,
               stall, redirect, redirect_pc,
        output ld_ready, inst, inst_pc, inst_valid, halted
    );
endinterface

// File: rtl/instr_fetch_mem_store.sv
// Instruction array with per-entry valid bits; invalid entries read back as the done word.
// Latency: write lands at the clock edge, read is combinational.
// Backpressure: none; the caller gates wr_en/clear.
module instr_store #(
    parameter int unsigned       IW      = instr_pkg::IW_DEF,
    parameter int unsigned       AW      = instr_pkg::AW_DEF,
    parameter int unsigned       OPW     = instr_pkg::OPW_DEF,
    parameter logic [OPW-1:0]    DONE_OP = instr_pkg::DONE_OP
) (
    input  logic          Clk,
    input  logic          Reset_n,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [IW-1:0] wr_dat,
    input  logic          clear,
    input  logic [AW-1:0] rd_addr,
    output logic [IW-1:0] rd_dat
);
    import instr_pkg::*;

    localparam int unsigned   DEPTH     = 1 << AW;
    localparam logic [IW-1:0] DONE_WORD = IW'(done_word(IW, OPW, 32'(DONE_OP)));

    logic [IW-1:0]    mem [DEPTH];
    logic [DEPTH-1:0] ent_vld_q;
    logic [DEPTH-1:0] ent_vld_d;

    // Valid-bit update: clear first, so a coincident write still marks its entry valid.
    always_comb begin
        ent_vld_d = ent_vld_q;
        if (clear) begin
            ent_vld_d = '0;
        end
        if (wr_en) begin
            ent_vld_d[wr_addr] = 1'b1;
        end
    end

    // Valid bits are the only reset state; the program is erased on reset.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            ent_vld_q <= '0;
        end else begin
            ent_vld_q <= ent_vld_d;
        end
    end

    // Data array write; contents are deliberately not reset.
    always_ff @(posedge Clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_dat;
        end
    end

    assign rd_dat = ent_vld_q[rd_addr] ? mem[rd_addr] : DONE_WORD;

endmodule

// File: rtl/instr_fetch_mem.sv
// Loadable instruction store with a registered fetch stage, PC wrap, redirect and halt on done.
// Latency: first instruction one edge after start; redirect target one edge after the redirect edge.
// Backpressure: stall holds pc and the output stage; redirect overrides stall; loads only when idle/halted.
module instr_fetch_mem #(
    parameter int unsigned    IW      = instr_pkg::IW_DEF,
    parameter int unsigned    AW      = instr_pkg::AW_DEF,
    parameter int unsigned    OPW     = instr_pkg::OPW_DEF,
    parameter logic [OPW-1:0] DONE_OP = instr_pkg::DONE_OP
) (
    input  logic          Clk,
    input  logic          Reset_n,
    instr_fetch_mem_if.slave bus
);
    import instr_pkg::*;

    state_e        state_q;
    state_e        state_d;
    logic [AW-1:0] pc_q;
    logic [AW-1:0] pc_d;
    logic [AW-1:0] inst_pc_q;
    logic [AW-1:0] inst_pc_d;
    logic [IW-1:0] inst_q;
    logic [IW-1:0] inst_d;
    logic          inst_vld_q;
    logic          inst_vld_d;
    logic [IW-1:0] rd_dat;
    logic          ld_ready;
    logic          halted;
    logic          done_take;

    instr_store #(
        .IW      (IW),
        .AW      (AW),
        .OPW     (OPW),
        .DONE_OP (DONE_OP)
    ) u_store (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .wr_en   (bus.ld_en & ld_ready),
        .wr_addr (bus.ld_addr),
        .wr_dat  (bus.ld_data),
        .clear   (bus.clear & ld_ready),
        .rd_addr (pc_q),
        .rd_dat  (rd_dat)
    );

    // FSM state register.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: start launches (or relaunches) fetch, a consumed done halts it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.start) state_d = S_RUN;
            S_RUN:   if (done_take) state_d = S_HALT;
            S_HALT:  if (bus.start) state_d = S_RUN;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs: load window, halt flag, and the done-consumed strobe.
    always_comb begin
        ld_ready  = (state_q != S_RUN);
        halted    = (state_q == S_HALT);
        done_take = (state_q == S_RUN) && inst_vld_q && !bus.stall &&
                    (get_op(32'(inst_q), IW, OPW) == 32'(DONE_OP));
    end

    // PC and output stage: done beats redirect, redirect beats stall, otherwise fetch.
    always_comb begin
        pc_d       = pc_q;
        inst_d     = inst_q;
        inst_pc_d  = inst_pc_q;
        inst_vld_d = inst_vld_q;
        if (state_q != S_RUN) begin
            if (bus.start) begin
                pc_d       = bus.start_pc;
                inst_vld_d = 1'b0;
            end
        end else if (done_take) begin
            inst_vld_d = 1'b0;
        end else if (bus.redirect) begin
            pc_d       = bus.redirect_pc;
            inst_vld_d = 1'b0;
        end else if (!bus.stall) begin
            inst_d     = rd_dat;
            inst_pc_d  = pc_q;
            inst_vld_d = 1'b1;
            pc_d       = pc_q + AW'(1);
        end
    end

    // Datapath registers.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            pc_q       <= '0;
            inst_q     <= '0;
            inst_pc_q  <= '0;
            inst_vld_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            inst_q     <= inst_d;
            inst_pc_q  <= inst_pc_d;
            inst_vld_q <= inst_vld_d;
        end
    end

    assign bus.ld_ready   = ld_ready;
    assign bus.halted     = halted;
    assign bus.inst       = inst_q;
    assign bus.inst_pc    = inst_pc_q;
    assign bus.inst_valid = inst_vld_q;

endmodule

// File: tb/tb_instr_fetch_mem.sv
// Directed and randomized checks of instr_fetch_mem against a behavioural reference model.
// Latency: model is advanced once per clock edge and compared 1 ns after the edge.
// Backpressure: stall/redirect/start/load driven directly by the bench.
module tb_instr_fetch_mem;

    localparam logic [19:0] DONE_W  = 20'h70000;
    localparam logic [4:0]  DONE_OC = 5'b01110;

    logic Clk;
    logic Reset_n;

    instr_fetch_mem_if bus ();

    instr_fetch_mem dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int nerr = 0;
    int nchk = 0;

    // Reference model: program as an array of (word, loaded) plus the visible fetch state.
    logic [19:0] m_mem [512];
    bit          m_ev  [512];
    bit          m_run;
    bit          m_halt;
    bit          m_vld;
    int          m_pc;
    int          m_ipc;
    logic [19:0] m_inst;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outs(input string tag);
        check({tag, ".inst"},       32'(bus.inst),       32'(m_inst));
        check({tag, ".inst_pc"},    32'(bus.inst_pc),    32'(m_ipc));
        check({tag, ".inst_valid"}, 32'(bus.inst_valid), 32'(m_vld));
        check({tag, ".halted"},     32'(bus.halted),     32'(m_halt));
        check({tag, ".ld_ready"},   32'(bus.ld_ready),   32'(!m_run));
    endtask

    function automatic logic [19:0] model_word(input int a);
        return m_ev[a] ? m_mem[a] : DONE_W;
    endfunction

    // Advance the model by one edge from the current inputs, clock, then compare.
    task automatic tick(input string tag);
        if (!m_run) begin
            if (bus.clear) begin
                for (int i = 0; i < 512; i++) m_ev[i] = 1'b0;
            end
            if (bus.ld_en) begin
                m_mem[int'(bus.ld_addr)] = bus.ld_data;
                m_ev[int'(bus.ld_addr)]  = 1'b1;
            end
            if (bus.start) begin
                m_run  = 1'b1;
                m_halt = 1'b0;
                m_pc   = int'(bus.start_pc);
                m_vld  = 1'b0;
            end
        end else if (m_vld && !bus.stall && (m_inst >> 15) == 20'(DONE_OC)) begin
            m_run  = 1'b0;
            m_halt = 1'b1;
            m_vld  = 1'b0;
        end else if (bus.redirect) begin
            m_pc  = int'(bus.redirect_pc);
            m_vld = 1'b0;
        end else if (!bus.stall) begin
            m_inst = model_word(m_pc);
            m_ipc  = m_pc;
            m_vld  = 1'b1;
            m_pc   = (m_pc + 1) % 512;
        end
        @(posedge Clk);
        #1;
        check_outs(tag);
    endtask

    task automatic idle_inputs();
        bus.ld_en       = 1'b0;
        bus.ld_addr     = '0;
        bus.ld_data     = '0;
        bus.clear       = 1'b0;
        bus.start       = 1'b0;
        bus.start_pc    = '0;
        bus.stall       = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 512; i++) m_ev[i] = 1'b0;
        m_run  = 1'b0;
        m_halt = 1'b0;
        m_vld  = 1'b0;
        m_pc   = 0;
        m_ipc  = 0;
        m_inst = '0;
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic do_reset(input string tag);
        Reset_n = 1'b0;
        #2;
        model_reset();
        check_outs(tag);
        #3;
        Reset_n = 1'b1;
    endtask

    task automatic load(input int a, input logic [19:0] d);
        bus.ld_en   = 1'b1;
        bus.ld_addr = 9'(a);
        bus.ld_data = d;
        tick("load");
        bus.ld_en   = 1'b0;
        bus.clear   = 1'b0;
    endtask

    task automatic start_at(input int a);
        bus.start    = 1'b1;
        bus.start_pc = 9'(a);
        tick("start");
        bus.start    = 1'b0;
    endtask

    task automatic run_to_halt(input string tag);
        for (int i = 0; i < 64 && !bus.halted; i++) tick(tag);
        check({tag, ".reached_halt"}, 32'(bus.halted), 32'd1);
    endtask

    function automatic int rnd_addr();
        int a;
        a = int'($urandom_range(0, 47));
        return (a < 32) ? a : a + 464;
    endfunction

    function automatic logic [19:0] rnd_word();
        logic [19:0] w;
        w = 20'($urandom);
        if ($urandom_range(0, 5) == 0) w[19:15] = DONE_OC;
        return w;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        idle_inputs();
        model_reset();
        Reset_n = 1'b0;
        #12;
        check_outs("reset");
        check("reset.inst_const", 32'(bus.inst), 32'd0);
        check("reset.ld_ready_const", 32'(bus.ld_ready), 32'd1);
        Reset_n = 1'b1;

        // Empty memory: done word fetched from PC 0, then halt.
        start_at(0);
        tick("empty.f0");
        check("empty.inst", 32'(bus.inst), 32'h70000);
        check("empty.vld", 32'(bus.inst_valid), 32'd1);
        tick("empty.halt");
        check("empty.halted", 32'(bus.halted), 32'd1);
        check("empty.vld_off", 32'(bus.inst_valid), 32'd0);

        // Three-word program with a two-cycle stall on PC 1.
        load(0, 20'h11000);
        load(1, 20'h22000);
        load(2, 20'h70000);
        start_at(0);
        tick("prog.f0");
        check("prog.pc0", 32'(bus.inst_pc), 32'd0);
        check("prog.inst0", 32'(bus.inst), 32'h11000);
        tick("prog.f1");
        check("prog.inst1", 32'(bus.inst), 32'h22000);
        bus.stall = 1'b1;
        tick("prog.stall1");
        tick("prog.stall2");
        check("prog.stall_pc", 32'(bus.inst_pc), 32'd1);
        check("prog.stall_inst", 32'(bus.inst), 32'h22000);
        bus.stall = 1'b0;
        tick("prog.f2");
        check("prog.pc2", 32'(bus.inst_pc), 32'd2);
        tick("prog.halt");
        check("prog.halted", 32'(bus.halted), 32'd1);
        check("prog.ld_ready", 32'(bus.ld_ready), 32'd1);

        // Redirect, and redirect with stall; clear and write coincide on entry 0.
        bus.clear = 1'b1;
        load(0, 20'h01000);
        for (int i = 1; i < 8; i++) load(i, 20'h01000 + 20'(i));
        start_at(0);
        tick("redir.f0");
        tick("redir.f1");
        check("redir.pc1", 32'(bus.inst_pc), 32'd1);
        bus.redirect    = 1'b1;
        bus.redirect_pc = 9'd5;
        tick("redir.edge");
        check("redir.vld_off", 32'(bus.inst_valid), 32'd0);
        bus.redirect = 1'b0;
        tick("redir.tgt");
        check("redir.pc5", 32'(bus.inst_pc), 32'd5);
        check("redir.inst5", 32'(bus.inst), 32'h01005);
        bus.redirect    = 1'b1;
        bus.stall       = 1'b1;
        bus.redirect_pc = 9'd2;
        tick("redir_st.edge");
        check("redir_st.vld_off", 32'(bus.inst_valid), 32'd0);
        bus.redirect = 1'b0;
        bus.stall    = 1'b0;
        tick("redir_st.tgt");
        check("redir_st.pc2", 32'(bus.inst_pc), 32'd2);
        run_to_halt("redir.run");

        // PC wrap; the write to entry 0 lands on the start edge itself.
        bus.clear = 1'b1;
        load(511, 20'h11000);
        bus.ld_en   = 1'b1;
        bus.ld_addr = 9'd0;
        bus.ld_data = DONE_W;
        start_at(511);
        bus.ld_en = 1'b0;
        tick("wrap.f511");
        check("wrap.pc511", 32'(bus.inst_pc), 32'd511);
        tick("wrap.f0");
        check("wrap.pc0", 32'(bus.inst_pc), 32'd0);
        check("wrap.inst0", 32'(bus.inst), 32'h70000);
        tick("wrap.halt");
        check("wrap.halted", 32'(bus.halted), 32'd1);

        // Load during RUN is ignored; reset mid-RUN erases the program.
        bus.clear = 1'b1;
        load(0, 20'h01000);
        for (int i = 1; i < 8; i++) load(i, 20'h01000 + 20'(i));
        start_at(0);
        tick("ill.f0");
        bus.ld_en   = 1'b1;
        bus.ld_addr = 9'd3;
        bus.ld_data = DONE_W;
        tick("ill.f1");
        bus.ld_en = 1'b0;
        tick("ill.f2");
        tick("ill.f3");
        check("ill.inst3", 32'(bus.inst), 32'h01003);
        do_reset("midrst");
        check("midrst.ld_ready", 32'(bus.ld_ready), 32'd1);
        check("midrst.halted", 32'(bus.halted), 32'd0);
        check("midrst.vld", 32'(bus.inst_valid), 32'd0);
        start_at(0);
        tick("midrst.f0");
        check("midrst.inst0", 32'(bus.inst), 32'h70000);
        tick("midrst.halt");

        // Randomized traffic over a window that includes the wrap boundary.
        for (int r = 0; r < 6; r++) begin
            bus.clear = 1'b1;
            for (int k = 0; k < 24; k++) load(rnd_addr(), rnd_word());
            start_at(rnd_addr());
            for (int c = 0; c < 80; c++) begin
                bus.stall       = ($urandom_range(0, 9) < 3);
                bus.redirect    = ($urandom_range(0, 9) == 0);
                bus.redirect_pc = 9'(rnd_addr());
                bus.start       = ($urandom_range(0, 7) == 0);
                bus.start_pc    = 9'(rnd_addr());
                bus.ld_en       = ($urandom_range(0, 5) == 0);
                bus.ld_addr     = 9'(rnd_addr());
                bus.ld_data     = rnd_word();
                bus.clear       = ($urandom_range(0, 19) == 0);
                tick("rand");
            end
            idle_inputs();
            if (r == 2) do_reset("rand.rst");
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
